// File: rtl/cclk_pkg.sv
// Shared types and default timing constants for the cclk readiness driver
// and the matching cclk detector.
package cclk_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOW   = 2'd1,
      PULSE = 2'd2,
      HIGH  = 2'd3
   } cclk_state_t;

   function automatic int calc_half_period(input int clk_freq, input int cclk_freq);
      return clk_freq / (2 * cclk_freq);
   endfunction

   function automatic int calc_low_cycles(input int clk_freq);
      return clk_freq / 5000;
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   localparam int DEF_CLK_FREQ    = 50000000;
   localparam int DEF_CCLK_FREQ   = 1000000;
   localparam int DEF_HALF_PERIOD = calc_half_period(DEF_CLK_FREQ, DEF_CCLK_FREQ);
   localparam int DEF_LOW_CYCLES  = calc_low_cycles(DEF_CLK_FREQ);

endpackage

// File: rtl/cclk_tick_counter.sv
// Saturating up-counter with synchronous clear and a terminal-count flag
// that goes high when the count equals a run-time selectable last value.
module cclk_tick_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic         en,
   input  logic [W-1:0] last,
   output logic         tc
);

   logic [W-1:0] count_r;
   logic         tc_s;

   assign tc_s = (count_r == last);
   assign tc   = tc_s;

   // Count register: clear on load, advance while enabled, hold at terminal count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_r <= '0;
      end else if (load) begin
         count_r <= '0;
      end else if (en && !tc_s) begin
         count_r <= count_r + W'(1);
      end else begin
         count_r <= count_r;
      end
   end

endmodule

// File: rtl/cclk_driver.sv
// Host-side cclk driver: holds cclk low for a settle time, emits a burst of
// configuration pulses, then holds cclk high as the ready indication.
module cclk_driver
   import cclk_pkg::*;
#(
   parameter int CLK_FREQ    = DEF_CLK_FREQ,
   parameter int CCLK_FREQ   = DEF_CCLK_FREQ,
   parameter int HALF_PERIOD = calc_half_period(CLK_FREQ, CCLK_FREQ),
   parameter int LOW_CYCLES  = calc_low_cycles(CLK_FREQ),
   parameter int PULSE_COUNT = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic enable,
   input  logic reconfig,
   output logic cclk,
   output logic ready,
   output logic busy
);

   localparam int CYC_W = $clog2(max_int(LOW_CYCLES, HALF_PERIOD) + 1);
   localparam int PLS_W = max_int(1, $clog2(PULSE_COUNT + 1));

   localparam logic [CYC_W-1:0] LOW_LAST = CYC_W'(LOW_CYCLES - 1);
   localparam logic [CYC_W-1:0] HP_LAST  = CYC_W'(HALF_PERIOD - 1);
   localparam logic [PLS_W-1:0] PLS_LAST = (PULSE_COUNT > 0) ? PLS_W'(PULSE_COUNT - 1) : '0;
   localparam bit               NO_BURST = (PULSE_COUNT == 0);

   localparam logic [1:0] ST_IDLE  = IDLE;
   localparam logic [1:0] ST_LOW   = LOW;
   localparam logic [1:0] ST_PULSE = PULSE;
   localparam logic [1:0] ST_HIGH  = HIGH;

   logic [1:0]       state_r;
   logic [1:0]       state_nxt_s;
   logic             cclk_r;
   logic             cclk_nxt_s;
   logic             ready_r;
   logic             busy_r;
   logic             cyc_load_s;
   logic             cyc_en_s;
   logic             cyc_tc_s;
   logic [CYC_W-1:0] cyc_last_s;
   logic             pls_load_s;
   logic             pls_en_s;
   logic             pls_tc_s;

   cclk_tick_counter #(.W(CYC_W)) u_cyc_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (cyc_load_s),
      .en    (cyc_en_s),
      .last  (cyc_last_s),
      .tc    (cyc_tc_s)
   );

   cclk_tick_counter #(.W(PLS_W)) u_pls_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (pls_load_s),
      .en    (pls_en_s),
      .last  (PLS_LAST),
      .tc    (pls_tc_s)
   );

   // Next-state, next-cclk and counter control; enable=0 outranks reconfig.
   always_comb begin
      state_nxt_s = state_r;
      cclk_nxt_s  = cclk_r;
      cyc_load_s  = 1'b0;
      cyc_en_s    = 1'b0;
      cyc_last_s  = LOW_LAST;
      pls_load_s  = 1'b0;
      pls_en_s    = 1'b0;
      if (!enable) begin
         state_nxt_s = ST_IDLE;
         cclk_nxt_s  = 1'b0;
         cyc_load_s  = 1'b1;
         pls_load_s  = 1'b1;
      end else if (reconfig || (state_r == ST_IDLE)) begin
         state_nxt_s = ST_LOW;
         cclk_nxt_s  = 1'b0;
         cyc_load_s  = 1'b1;
         pls_load_s  = 1'b1;
      end else begin
         case (state_r)
            ST_LOW: begin
               if (cyc_tc_s) begin
                  cyc_load_s  = 1'b1;
                  cclk_nxt_s  = 1'b1;
                  state_nxt_s = NO_BURST ? ST_HIGH : ST_PULSE;
               end else begin
                  cyc_en_s = 1'b1;
               end
            end
            ST_PULSE: begin
               cyc_last_s = HP_LAST;
               if (cyc_tc_s) begin
                  cyc_load_s = 1'b1;
                  if (cclk_r) begin
                     cclk_nxt_s = 1'b0;
                  end else begin
                     // End of a low half closes one full period.
                     pls_en_s   = 1'b1;
                     cclk_nxt_s = 1'b1;
                     if (pls_tc_s) begin
                        state_nxt_s = ST_HIGH;
                     end else begin
                        state_nxt_s = ST_PULSE;
                     end
                  end
               end else begin
                  cyc_en_s = 1'b1;
               end
            end
            ST_HIGH: begin
               cclk_nxt_s = 1'b1;
            end
            default: begin
               state_nxt_s = ST_IDLE;
               cclk_nxt_s  = 1'b0;
               cyc_load_s  = 1'b1;
               pls_load_s  = 1'b1;
            end
         endcase
      end
   end

   // State and registered outputs, all decoded from the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         cclk_r  <= 1'b0;
         ready_r <= 1'b0;
         busy_r  <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         cclk_r  <= cclk_nxt_s;
         ready_r <= (state_nxt_s == ST_HIGH);
         busy_r  <= (state_nxt_s == ST_LOW) || (state_nxt_s == ST_PULSE);
      end
   end

   assign cclk  = cclk_r;
   assign ready = ready_r;
   assign busy  = busy_r;

endmodule

// File: tb/tb_cclk_driver.sv
// Self-checking bench for cclk_driver: a timeline model per instance plus
// hand-computed literal checkpoints (HALF_PERIOD=3, LOW_CYCLES=10).
module tb_cclk_driver;

   localparam int HP  = 3;
   localparam int LOW = 10;

   logic clk = 1'b0;
   logic rst_n;
   logic enable, reconfig, cclk, ready, busy;
   logic en0, rc0, cclk0, ready0, busy0;

   int tests = 0;
   int fails = 0;
   int t     = 0;
   int base  = 0;

   int cyc     = 0;
   bit run_a   = 1'b0;
   bit run_b   = 1'b0;
   int start_a = 0;
   int start_b = 0;

   always #5 clk = ~clk;

   cclk_driver #(.HALF_PERIOD(HP), .LOW_CYCLES(LOW), .PULSE_COUNT(2)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .reconfig(reconfig),
      .cclk(cclk), .ready(ready), .busy(busy)
   );

   cclk_driver #(.HALF_PERIOD(HP), .LOW_CYCLES(LOW), .PULSE_COUNT(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .enable(en0), .reconfig(rc0),
      .cclk(cclk0), .ready(ready0), .busy(busy0)
   );

   // Expected {cclk, ready, busy} k edges after the sequence start edge.
   function automatic logic [2:0] exp_out(input bit run, input int k, input int pc);
      if (!run)
         return 3'b000;
      if (k < LOW)
         return 3'b001;
      if (k < LOW + 2 * HP * pc)
         return {(((k - LOW) % (2 * HP)) < HP), 1'b0, 1'b1};
      return 3'b110;
   endfunction

   task automatic check(input string name, input logic [2:0] got, input logic [2:0] exp);
      tests = tests + 1;
      if (got !== exp) begin
         fails = fails + 1;
         $display("FAIL %s t=%0d got cclk/ready/busy=%b expected %b", name, t, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      t = t + 1;
   endtask

   task automatic at(input int k);
      while (t < base + k) tick();
   endtask

   // Timeline model: remember the edge at which each sequence (re)started.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_a <= 1'b0;
         run_b <= 1'b0;
      end else begin
         cyc <= cyc + 1;
         if (!enable) begin
            run_a <= 1'b0;
         end else if (!run_a || reconfig) begin
            run_a   <= 1'b1;
            start_a <= cyc + 1;
         end
         if (!en0) begin
            run_b <= 1'b0;
         end else if (!run_b || rc0) begin
            run_b   <= 1'b1;
            start_b <= cyc + 1;
         end
      end
   end

   // Cycle-by-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      check("model_pc2", {cclk, ready, busy}, exp_out(run_a, cyc - start_a, 2));
      check("model_pc0", {cclk0, ready0, busy0}, exp_out(run_b, cyc - start_b, 0));
   end

   initial begin
      enable = 1'b0; reconfig = 1'b0; en0 = 1'b0; rc0 = 1'b0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      tick();
      check("reset", {cclk, ready, busy}, 3'b000);
      check("reset_pc0", {cclk0, ready0, busy0}, 3'b000);
      tick();
      enable = 1'b1; en0 = 1'b1; rst_n = 1'b1;
      base = t + 1;

      // Power-up sequence
      at(9);  check("low_end", {cclk, ready, busy}, 3'b001);
              check("pc0_low_end", {cclk0, ready0, busy0}, 3'b001);
      at(10); check("first_rise", {cclk, ready, busy}, 3'b101);
              check("pc0_ready", {cclk0, ready0, busy0}, 3'b110);
      at(12); check("high1_end", {cclk, ready, busy}, 3'b101);
      at(13); check("fall1", {cclk, ready, busy}, 3'b001);
      at(16); check("rise2", {cclk, ready, busy}, 3'b101);
      at(19); check("fall2", {cclk, ready, busy}, 3'b001);
      at(21); check("pre_ready", {cclk, ready, busy}, 3'b001);
      at(22); check("ready", {cclk, ready, busy}, 3'b110);

      // Reconfig in HIGH
      at(29); reconfig = 1'b1;
      at(30); check("reconfig_high", {cclk, ready, busy}, 3'b001); reconfig = 1'b0;
      at(51); check("re_pre_ready", {cclk, ready, busy}, 3'b001);
      at(52); check("re_ready", {cclk, ready, busy}, 3'b110);

      // Reconfig during the second high half
      at(59); reconfig = 1'b1;
      at(60); reconfig = 1'b0;
      at(76); check("second_high", {cclk, ready, busy}, 3'b101); reconfig = 1'b1;
      at(77); check("reconfig_pulse", {cclk, ready, busy}, 3'b001); reconfig = 1'b0;
      at(98); check("rp_pre_ready", {cclk, ready, busy}, 3'b001);
      at(99); check("rp_ready", {cclk, ready, busy}, 3'b110);

      // Drop enable mid-LOW, re-raise 5 cycles later
      at(104); reconfig = 1'b1;
      at(105); reconfig = 1'b0;
      at(107); enable = 1'b0;
      at(108); check("enable_drop", {cclk, ready, busy}, 3'b000);
      at(112); enable = 1'b1;
      at(122); check("reen_low_end", {cclk, ready, busy}, 3'b001);
      at(123); check("reen_rise", {cclk, ready, busy}, 3'b101);

      // Asynchronous reset mid-PULSE
      at(125);
      #2 rst_n = 1'b0;
      #1 check("async_reset", {cclk, ready, busy}, 3'b000);
      check("async_reset_pc0", {cclk0, ready0, busy0}, 3'b000);
      at(128); rst_n = 1'b1;
      at(138); check("rst_low_end", {cclk, ready, busy}, 3'b001);
      at(139); check("rst_rise", {cclk, ready, busy}, 3'b101);
               check("rst_pc0_ready", {cclk0, ready0, busy0}, 3'b110);
      at(151); check("rst_ready", {cclk, ready, busy}, 3'b110);

      // enable=0 and reconfig=1 together: enable wins
      at(159); enable = 1'b0; reconfig = 1'b1;
      at(160); check("en_wins", {cclk, ready, busy}, 3'b000); reconfig = 1'b0;
      at(163); check("stay_idle", {cclk, ready, busy}, 3'b000);
      at(165); enable = 1'b1;
      at(176); check("final_rise", {cclk, ready, busy}, 3'b101);
      at(180);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
